// File: rtl/decoder_arb_if.sv
// rtl/decoder_arb_if.sv - request/grant bundle between requesters and the decoder arbiter
//
// Signals:
//   req     [3:0]  per-channel request toward the arbiter
//   done           early release of the current grant
//   dec_sel [1:0]  channel select to the downstream 1-to-4 decoder
//   dec_in         decoder data/enable bit, high only while a grant is active
//   busy           arbiter is holding a grant
// Modports:
//   master  requester side (drives req/done, observes the decoder outputs)
//   slave   arbiter side (observes req/done, drives the decoder outputs)
interface decoder_arb_if;
  logic [3:0] req;
  logic       done;
  logic [1:0] dec_sel;
  logic       dec_in;
  logic       busy;

  modport master (
    output req,
    output done,
    input  dec_sel,
    input  dec_in,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output dec_sel,
    output dec_in,
    output busy
  );
endinterface

// File: rtl/decoder_arb.sv
// rtl/decoder_arb.sv - four-channel arbiter that drives the select/enable of a 1-to-4 decoder
//
// Grants one requesting channel at a time for at most HOLD cycles, with a
// mandatory idle cycle between grants. Arbitration is round-robin by default;
// defining DECODER_ARB_FIXED_PRIO_EN switches to fixed lowest-index priority.
//
// Parameters:
//   HOLD   1..15, maximum number of cycles one grant is held
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    decoder_arb_if.slave: req/done in, dec_sel/dec_in/busy out
//          (all outputs come straight from flops)
module decoder_arb #(
  parameter int HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_arb_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The first grant cycle loads HOLD-1 and the grant drops after the cycle
  // that sees zero, giving exactly HOLD high cycles.
  localparam logic [3:0] CNT_INIT = 4'(HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] dec_sel_q, dec_sel_d;
  logic       dec_in_q, dec_in_d;
  logic       busy_q, busy_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0] winner;
  logic       release_now;

  // Winner search. Scanning from the far end and overwriting leaves the
  // first hit of the forward search in winner.
  always_comb begin
    winner = 2'd0;
`ifdef DECODER_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) winner = 2'(i);
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[2'(ptr_q + 2'(i))]) winner = 2'(ptr_q + 2'(i));
    end
`endif
  end

  // Any single cause ends the grant; coincident causes still give one release.
  assign release_now = (cnt_q == 4'd0) || bus.done || !bus.req[dec_sel_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dec_sel_q <= 2'b00;
      dec_in_q  <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 4'd0;
      ptr_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      dec_sel_q <= dec_sel_d;
      dec_in_q  <= dec_in_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req)    state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: computes next values of the registered outputs so nothing
  // on the bus is combinational from an input.
  always_comb begin
    dec_sel_d = dec_sel_q;
    dec_in_d  = dec_in_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        dec_in_d = 1'b0;
        busy_d   = 1'b0;
        if (|bus.req) begin
          dec_sel_d = winner;
          dec_in_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = CNT_INIT;
        end
      end
      GRANT: begin
        if (release_now) begin
          dec_in_d = 1'b0;
          busy_d   = 1'b0;
`ifndef DECODER_ARB_FIXED_PRIO_EN
          ptr_d    = dec_sel_q + 2'd1;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        dec_in_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign bus.dec_sel = dec_sel_q;
  assign bus.dec_in  = dec_in_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_decoder_arb.sv
// tb/tb_decoder_arb.sv - directed self-checking bench for decoder_arb (HOLD=4)
module tb_decoder_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  decoder_arb_if bus();

  decoder_arb #(.HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    do_reset();

    chk("rst_sel",  bus.dec_sel, 2'b00);
    chk("rst_in",   bus.dec_in,  1'b0);
    chk("rst_busy", bus.busy,    1'b0);

`ifdef DECODER_ARB_FIXED_PRIO_EN
    bus.req = 4'b1010;
    for (int c = 1; c <= 15; c++) begin
      tick();
      chk($sformatf("fix_sel_c%0d", c), bus.dec_sel, 2'b01);
      chk($sformatf("fix_in_c%0d", c), bus.dec_in, ((c - 1) % 5) < 4);
    end
`else
    // Single requester: high cycles 1..4, low at 5, high again at 6
    begin
      logic exp_in [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      bus.req = 4'b0001;
      for (int c = 1; c <= 6; c++) begin
        tick();
        chk($sformatf("hold_in_c%0d", c), bus.dec_in, exp_in[c-1]);
        chk($sformatf("hold_busy_c%0d", c), bus.busy, exp_in[c-1]);
        chk($sformatf("hold_sel_c%0d", c), bus.dec_sel, 2'b00);
      end
    end

    // All requesting: 0,1,2,3,0 each for 4 cycles plus one idle cycle
    do_reset();
    bus.req = 4'b1111;
    for (int c = 1; c <= 25; c++) begin
      tick();
      chk($sformatf("rr_in_c%0d", c), bus.dec_in, ((c - 1) % 5) < 4);
      chk($sformatf("rr_sel_c%0d", c), bus.dec_sel, ((c - 1) / 5) % 4);
    end

    // Channel 2 granted, done pulsed during the 2nd grant cycle
    do_reset();
    bus.req = 4'b1100;
    tick();
    chk("done_g1_sel", bus.dec_sel, 2'd2);
    chk("done_g1_in",  bus.dec_in,  1'b1);
    tick();
    chk("done_g2_in",  bus.dec_in,  1'b1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("done_rel_in",   bus.dec_in,  1'b0);
    chk("done_rel_busy", bus.busy,    1'b0);
    chk("done_rel_sel",  bus.dec_sel, 2'd2);
    tick();
    chk("done_next_sel", bus.dec_sel, 2'd3);
    chk("done_next_in",  bus.dec_in,  1'b1);

    // Channel 1 granted; other bits toggle harmlessly, then req[1] drops
    do_reset();
    bus.req = 4'b0010;
    tick();
    chk("drop_g_sel", bus.dec_sel, 2'd1);
    bus.req = 4'b1011;
    tick();
    chk("drop_other_in",  bus.dec_in,  1'b1);
    chk("drop_other_sel", bus.dec_sel, 2'd1);
    bus.req = 4'b1001;
    tick();
    chk("drop_rel_in",   bus.dec_in,  1'b0);
    chk("drop_rel_busy", bus.busy,    1'b0);
    tick();
    chk("drop_next_sel", bus.dec_sel, 2'd3);
    chk("drop_next_in",  bus.dec_in,  1'b1);

    // done coincides with the last counted cycle: one release, ptr -> 1
    do_reset();
    bus.req = 4'b0101;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("coin_in_c%0d", c), bus.dec_in, 1'b1);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("coin_rel_in",  bus.dec_in,  1'b0);
    chk("coin_rel_sel", bus.dec_sel, 2'd0);
    tick();
    chk("coin_next_sel", bus.dec_sel, 2'd2);
    chk("coin_next_in",  bus.dec_in,  1'b1);

    // Asynchronous reset during a grant to channel 3
    do_reset();
    bus.req = 4'b1000;
    tick();
    chk("arst_g_sel", bus.dec_sel, 2'd3);
    chk("arst_g_in",  bus.dec_in,  1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel",  bus.dec_sel, 2'd0);
    chk("arst_in",   bus.dec_in,  1'b0);
    chk("arst_busy", bus.busy,    1'b0);
    bus.req = 4'b1001;
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_next_sel", bus.dec_sel, 2'd0);
    chk("arst_next_in",  bus.dec_in,  1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
